hbm_req_arbiter: RTL and testbench

Shares one HBM controller command/write-data channel among NUM_REQ compute-core requesters and routes returning read data back to the requester that issued each read. Sits between the cores and the core-side port of the HBM controller wrapper: it round-robin arbitrates 25-bit commands into a one-entry registered output stage. It also tracks in-flight reads in a tag FIFO, because the controller returns read data in order and without backpressure.

---
 rtl/hbm_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_hbm_req_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_req_arbiter.sv
// hbm_req_arbiter: round-robin sharing of one HBM controller command/write-data channel among
// NUM_REQ requesters, with an in-order tag FIFO that steers returning read beats back to the
// requester that issued each read.
// Optional feature macro: HBM_ARB_UNDERFLOW_CHK_EN (sticky flag for read returns with no tag).

module hbm_req_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 1024,
    parameter int unsigned CMD_W    = 25,
    parameter int unsigned RD_DEPTH = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*CMD_W-1:0]      i_req_command,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_wdata,
    output logic [NUM_REQ-1:0]            o_rd_valid,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_command_valid,
    input  logic                          i_controller_ready,
    output logic [CMD_W-1:0]              o_command,
    output logic [DATA_W-1:0]             o_write_data,
    input  logic                          i_read_data_valid,
    input  logic [DATA_W-1:0]             i_read_data,
    output logic [$clog2(RD_DEPTH):0]     o_rd_outstanding,
    output logic                          o_rd_underflow
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(RD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OP_BIT = CMD_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RD_DEPTH);

    logic [CMD_W-1:0]  req_cmd   [NUM_REQ];
    logic [DATA_W-1:0] req_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;

    logic              stg_valid_q;
    logic [CMD_W-1:0]  stg_cmd_q;
    logic [DATA_W-1:0] stg_wdata_q;
    logic [ID_W-1:0]   rr_ptr_q;

    logic [ID_W-1:0]   tag_mem [RD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              fifo_full;
    logic              stage_free;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic              accept;
    logic              push;
    logic              pop;

    // Full blocks reads even when a pop lands in the same cycle; writes are never blocked.
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign stage_free = !stg_valid_q || i_controller_ready;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_cmd[gi]   = i_req_command[gi*CMD_W +: CMD_W];
        assign req_wdata[gi] = i_req_wdata[gi*DATA_W +: DATA_W];
        assign eligible[gi]  = i_req_valid[gi] && (!req_cmd[gi][OP_BIT] || !fifo_full);
    end

    // Round-robin search: first eligible requester at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign accept      = gnt_found && stage_free && !ap_rst;
    assign o_req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign push        = accept && req_cmd[gnt_idx][OP_BIT];
    assign pop         = i_read_data_valid && (cnt_q != '0);

    // Read data is broadcast; only the strobe is steered by the FIFO head tag.
    assign o_rd_valid = pop ? (NUM_REQ'(1) << tag_mem[rd_ptr_q]) : '0;
    assign o_rd_data  = i_read_data;

    // Output stage: loads on accept, empties when the controller takes it without a refill.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stg_valid_q <= 1'b0;
            stg_cmd_q   <= '0;
            stg_wdata_q <= '0;
        end else if (accept) begin
            stg_valid_q <= 1'b1;
            stg_cmd_q   <= req_cmd[gnt_idx];
            stg_wdata_q <= req_wdata[gnt_idx];
        end else if (i_controller_ready) begin
            stg_valid_q <= 1'b0;
        end
    end

    assign o_command_valid = stg_valid_q;
    assign o_command       = stg_cmd_q;
    assign o_write_data    = stg_wdata_q;

    // Round-robin pointer moves past the winner only when something is accepted.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
        end
    end

    // Tag FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Tag FIFO pointers and count; reset discards every in-flight tag.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // Tag storage needs no reset: an entry is always written before the count exposes it.
    always_ff @(posedge ap_clk) begin
        if (push) tag_mem[wr_ptr_q] <= gnt_idx;
    end

    assign o_rd_outstanding = cnt_q;

`ifdef HBM_ARB_UNDERFLOW_CHK_EN
    logic underflow_q;

    // Sticky flag for a read beat that arrives with no tag to route it.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            underflow_q <= 1'b0;
        end else if (i_read_data_valid && (cnt_q == '0)) begin
            underflow_q <= 1'b1;
        end
    end

    assign o_rd_underflow = underflow_q;
`else
    assign o_rd_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_hbm_req_arbiter.sv
// Self-checking bench for hbm_req_arbiter: grant/command scoreboard plus a read-return table.

module tb_hbm_req_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 64;
    localparam int CMD_W    = 25;
    localparam int RD_DEPTH = 16;

    logic                      ap_clk;
    logic                      ap_rst;
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [NUM_REQ*CMD_W-1:0]  i_req_command;
    logic [NUM_REQ*DATA_W-1:0] i_req_wdata;
    logic [NUM_REQ-1:0]        o_rd_valid;
    logic [DATA_W-1:0]         o_rd_data;
    logic                      o_command_valid;
    logic                      i_controller_ready;
    logic [CMD_W-1:0]          o_command;
    logic [DATA_W-1:0]         o_write_data;
    logic                      i_read_data_valid;
    logic [DATA_W-1:0]         i_read_data;
    logic [$clog2(RD_DEPTH):0] o_rd_outstanding;
    logic                      o_rd_underflow;

    hbm_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CMD_W   (CMD_W),
        .RD_DEPTH(RD_DEPTH)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst            (ap_rst),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_command     (i_req_command),
        .i_req_wdata       (i_req_wdata),
        .o_rd_valid        (o_rd_valid),
        .o_rd_data         (o_rd_data),
        .o_command_valid   (o_command_valid),
        .i_controller_ready(i_controller_ready),
        .o_command         (o_command),
        .o_write_data      (o_write_data),
        .i_read_data_valid (i_read_data_valid),
        .i_read_data       (i_read_data),
        .o_rd_outstanding  (o_rd_outstanding),
        .o_rd_underflow    (o_rd_underflow)
    );

    typedef struct {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] wd;
    } exp_t;

    typedef struct {
        logic              dv;
        logic [DATA_W-1:0] data;
        logic [3:0]        exp_rv;
        int                exp_out;
    } rt_t;

    exp_t exp_q[$];
    int   gnt_q[$];
    rt_t  rtab[5];

    int n_checks = 0;
    int n_fail   = 0;
    logic               acc_prev;
    logic [NUM_REQ-1:0] acc_vec;
    logic [NUM_REQ-1:0] drop_mask;

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk_cmd(input logic rd, input int id, input int n);
        return {rd, 2'b01, 22'(id * 4096 + n)};
    endfunction

    function automatic logic [DATA_W-1:0] mk_wd(input int id, input int n);
        return {32'hA500_0000 + 32'(id * 256 + n), 32'(n * 7 + id)};
    endfunction

    task automatic set_req(input int i, input logic rd, input int n);
        i_req_command[i*CMD_W +: CMD_W]   = mk_cmd(rd, i, n);
        i_req_wdata[i*DATA_W +: DATA_W]   = mk_wd(i, n);
        i_req_valid[i]                    = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic rd, input int n);
        exp_t e;
        e.cmd = mk_cmd(rd, i, n);
        e.wd  = mk_wd(i, n);
        gnt_q.push_back(i);
        exp_q.push_back(e);
    endtask

    // One clock: scoreboard checks at the falling edge, accepted requesters released after
    // the rising edge.
    task automatic tick();
        exp_t e;
        int   g;
        @(negedge ap_clk);
        if (acc_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cmd_sb_empty: got staged command %0h expected none", o_command);
            end else begin
                e = exp_q.pop_front();
                check("cmd_valid_after_accept", 64'(o_command_valid), 64'd1);
                check("command", 64'(o_command), 64'(e.cmd));
                check("write_data", o_write_data, e.wd);
            end
        end
        acc_vec  = o_req_ready;
        acc_prev = (o_req_ready != '0);
        if (acc_prev) begin
            if (gnt_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got ready %0b expected none", o_req_ready);
            end else begin
                g = gnt_q.pop_front();
                check("grant", 64'(o_req_ready), 64'(1) << g);
            end
        end
        @(posedge ap_clk);
        #1;
        i_req_valid = i_req_valid & ~(acc_vec & drop_mask);
    endtask

    initial begin
        rtab[0] = '{dv: 1'b1, data: 64'hA, exp_rv: 4'b0001, exp_out: 2};
        rtab[1] = '{dv: 1'b1, data: 64'hB, exp_rv: 4'b0100, exp_out: 1};
        rtab[2] = '{dv: 1'b0, data: 64'h5, exp_rv: 4'b0000, exp_out: 1};
        rtab[3] = '{dv: 1'b1, data: 64'hC, exp_rv: 4'b0010, exp_out: 0};
        rtab[4] = '{dv: 1'b1, data: 64'hD, exp_rv: 4'b0000, exp_out: 0};

        ap_rst             = 1'b0;
        i_req_valid        = '0;
        i_req_command      = '0;
        i_req_wdata        = '0;
        i_controller_ready = 1'b1;
        i_read_data_valid  = 1'b0;
        i_read_data        = '0;
        drop_mask          = '1;
        acc_prev           = 1'b0;
        acc_vec            = '0;

        // Reset values, with all requesters already presenting writes.
        #1 ap_rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, i + 1);
        #2;
        check("rst_cmd_valid", 64'(o_command_valid), 64'd0);
        check("rst_command", 64'(o_command), 64'd0);
        check("rst_wdata", o_write_data, 64'd0);
        check("rst_outstanding", 64'(o_rd_outstanding), 64'd0);
        check("rst_underflow", 64'(o_rd_underflow), 64'd0);
        check("rst_ready", 64'(o_req_ready), 64'd0);
        check("rst_rd_valid", 64'(o_rd_valid), 64'd0);

        // Four writes at once: grants 0,1,2,3 on consecutive cycles.
        for (int i = 0; i < NUM_REQ; i++) push_exp(i, 1'b0, i + 1);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        repeat (5) tick();
        check("t1_stage_drained", 64'(o_command_valid), 64'd0);

        // Requesters 1 and 3 held continuously: grants alternate 1,3,1,3.
        drop_mask = '0;
        set_req(1, 1'b0, 11);
        set_req(3, 1'b0, 13);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_exp(1, 1'b0, 11);
            else push_exp(3, 1'b0, 13);
        end
        repeat (6) tick();
        i_req_valid = '0;
        drop_mask   = '1;
        tick();

        // Controller stall for 5 cycles with a command staged.
        i_controller_ready = 1'b0;
        set_req(2, 1'b0, 5);
        push_exp(2, 1'b0, 5);
        tick();
        set_req(0, 1'b0, 7);
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            check("stall_ready", 64'(o_req_ready), 64'd0);
            check("stall_valid", 64'(o_command_valid), 64'd1);
            check("stall_command", 64'(o_command), 64'(mk_cmd(1'b0, 2, 5)));
            check("stall_wdata", o_write_data, mk_wd(2, 5));
        end
        i_controller_ready = 1'b1;
        push_exp(0, 1'b0, 7);
        tick();
        tick();
        check("t3_stage_drained", 64'(o_command_valid), 64'd0);

        // Requester 2 fills the tag FIFO with 16 reads; a 17th is held off.
        drop_mask = 4'b1011;
        set_req(2, 1'b1, 0);
        repeat (RD_DEPTH) push_exp(2, 1'b1, 0);
        repeat (RD_DEPTH + 1) tick();
        #1;
        check("full_outstanding", 64'(o_rd_outstanding), 64'(RD_DEPTH));
        check("full_read_blocked", 64'(o_req_ready), 64'd0);
        set_req(0, 1'b0, 3);
        push_exp(0, 1'b0, 3);
        tick();
        tick();
        check("full_write_passes_outstanding", 64'(o_rd_outstanding), 64'(RD_DEPTH));
        i_read_data_valid = 1'b1;
        i_read_data       = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("full_pop_rd_valid", 64'(o_rd_valid), 64'b0100);
        check("full_pop_rd_data", o_rd_data, 64'h1234_5678_9ABC_DEF0);
        check("full_pop_still_blocked", 64'(o_req_ready), 64'd0);
        tick();
        i_read_data_valid = 1'b0;
        push_exp(2, 1'b1, 0);
        #1;
        check("reenabled_ready", 64'(o_req_ready), 64'b0100);
        check("after_pop_outstanding", 64'(o_rd_outstanding), 64'(RD_DEPTH - 1));
        tick();
        i_req_valid[2] = 1'b0;
        tick();
        check("refill_outstanding", 64'(o_rd_outstanding), 64'(RD_DEPTH));
        for (int k = 0; k < RD_DEPTH; k++) begin
            i_read_data_valid = 1'b1;
            i_read_data       = 64'hF00D_0000_0000_0000 + 64'(k);
            #1;
            check("drain_rd_valid", 64'(o_rd_valid), 64'b0100);
            check("drain_rd_data", o_rd_data, 64'hF00D_0000_0000_0000 + 64'(k));
            tick();
        end
        i_read_data_valid = 1'b0;
        check("drain_outstanding", 64'(o_rd_outstanding), 64'd0);
        drop_mask = '1;

        // Reads from 0, 2, 1 then returns routed from the table.
        set_req(0, 1'b1, 20);
        push_exp(0, 1'b1, 20);
        tick();
        set_req(2, 1'b1, 22);
        push_exp(2, 1'b1, 22);
        tick();
        set_req(1, 1'b1, 21);
        push_exp(1, 1'b1, 21);
        tick();
        tick();
        check("three_reads_outstanding", 64'(o_rd_outstanding), 64'd3);
        for (int r = 0; r < 5; r++) begin
            i_read_data_valid = rtab[r].dv;
            i_read_data       = rtab[r].data;
            #1;
            check("ret_rd_valid", 64'(o_rd_valid), 64'(rtab[r].exp_rv));
            check("ret_rd_data", o_rd_data, rtab[r].data);
            tick();
            check("ret_outstanding", 64'(o_rd_outstanding), 64'(rtab[r].exp_out));
        end
        i_read_data_valid = 1'b0;
`ifdef HBM_ARB_UNDERFLOW_CHK_EN
        check("underflow_set", 64'(o_rd_underflow), 64'd1);
        repeat (3) tick();
        check("underflow_held", 64'(o_rd_underflow), 64'd1);
`else
        check("underflow_tied_off", 64'(o_rd_underflow), 64'd0);
        repeat (3) tick();
        check("underflow_still_off", 64'(o_rd_underflow), 64'd0);
`endif

        // Reset mid-operation: staged read and its tag are discarded.
        i_controller_ready = 1'b0;
        drop_mask          = '0;
        set_req(1, 1'b1, 9);
        gnt_q.push_back(1);
        tick();
        check("pre_rst_staged", 64'(o_command_valid), 64'd1);
        check("pre_rst_outstanding", 64'(o_rd_outstanding), 64'd1);
        ap_rst   = 1'b1;
        acc_prev = 1'b0;
        acc_vec  = '0;
        exp_q.delete();
        #1;
        check("midrst_cmd_valid", 64'(o_command_valid), 64'd0);
        check("midrst_command", 64'(o_command), 64'd0);
        check("midrst_outstanding", 64'(o_rd_outstanding), 64'd0);
        check("midrst_underflow", 64'(o_rd_underflow), 64'd0);
        check("midrst_ready", 64'(o_req_ready), 64'd0);
        @(posedge ap_clk);
        #1;
        ap_rst             = 1'b0;
        i_req_valid        = '0;
        i_controller_ready = 1'b1;
        drop_mask          = '1;
        i_read_data_valid  = 1'b1;
        i_read_data        = 64'hDEAD;
        #1;
        check("post_rst_return_dropped", 64'(o_rd_valid), 64'd0);
        tick();
        i_read_data_valid = 1'b0;
`ifdef HBM_ARB_UNDERFLOW_CHK_EN
        check("post_rst_underflow", 64'(o_rd_underflow), 64'd1);
`else
        check("post_rst_underflow", 64'(o_rd_underflow), 64'd0);
`endif
        tick();
        check("post_rst_outstanding", 64'(o_rd_outstanding), 64'd0);

        check("grant_queue_empty", 64'(gnt_q.size()), 64'd0);
        check("cmd_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
